// File: rtl/ped_pkg.sv
// Shared types for the pedestrian request path and the traffic-light controller.
// Blink option (PED_WAIT_BLINK_EN) lives in ped_request.
package ped_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_COOLDOWN = 2'd2
    } ped_state_e;

    localparam int TIMER_W = 30;
    localparam int DEB_W   = 19;

    // Reload value for a down-counter that spans n cycles; 0 when n is 0.
    function automatic logic [TIMER_W-1:0] span_load(input int unsigned n);
        if (n == 0) begin
            return '0;
        end
        return TIMER_W'(n - 1);
    endfunction

endpackage

// File: rtl/ped_debounce.sv
// Button synchroniser, debounce counter and press (1->0) pulse generator.
// Level is accepted once the synchronised input differs for DEBOUNCE_CYCLES.
module ped_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 320000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_n,
    output logic deb,
    output logic press
);

    localparam logic [DEB_W-1:0] DEB_LIM = DEB_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic             deb_prev_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic [DEB_W-1:0] cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + DEB_W'(1);
        deb_d   = deb_q;
        cnt_d   = '0;
        if (sync2_q != deb_q) begin
            if (cnt_inc == DEB_LIM) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= button_n;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    assign deb   = deb_q;
    assign press = deb_prev_q & ~deb_q;

endmodule

// File: rtl/ped_request.sv
// Pedestrian request FSM: latches a press, holds ped_req until ack, then cools down.
// Define PED_WAIT_BLINK_EN to blink the WAIT lamp at 1 Hz while pending.
module ped_request
    import ped_pkg::*;
#(
    parameter int TIMER_SCALE     = 16000000,
    parameter int DEBOUNCE_CYCLES = 320000,
    parameter int COOLDOWN_S      = 5
) (
    input  logic pin3_clk_16mhz,
    input  logic pin2_rst_n,
    input  logic pin9_button_n,
    input  logic ped_ack,
    output logic ped_req,
    output logic pin10_wait_lamp,
    output logic press_seen
);

    localparam logic [TIMER_W-1:0] CD_LOAD =
        span_load(COOLDOWN_S * TIMER_SCALE);

    logic               press;
    logic               deb_unused;
    ped_state_e         state_q;
    ped_state_e         state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic               ped_req_q;
    logic               lamp_q;
    logic               lamp_d;
    logic               press_seen_q;

    ped_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (pin3_clk_16mhz),
        .rst_n   (pin2_rst_n),
        .button_n(pin9_button_n),
        .deb     (deb_unused),
        .press   (press)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (ped_ack) begin
                    if (COOLDOWN_S != 0) begin
                        state_d = ST_COOLDOWN;
                        timer_d = CD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef PED_WAIT_BLINK_EN
    localparam logic [TIMER_W-1:0] HALF_LOAD = span_load(TIMER_SCALE / 2);

    logic [TIMER_W-1:0] blink_q;
    logic [TIMER_W-1:0] blink_d;

    // Lamp starts lit on entry, then toggles each half second.
    always_comb begin
        blink_d = blink_q;
        lamp_d  = 1'b0;
        if (state_d == ST_PENDING) begin
            if (state_q != ST_PENDING) begin
                blink_d = HALF_LOAD;
                lamp_d  = 1'b1;
            end else if (blink_q == '0) begin
                blink_d = HALF_LOAD;
                lamp_d  = ~lamp_q;
            end else begin
                blink_d = blink_q - TIMER_W'(1);
                lamp_d  = lamp_q;
            end
        end
    end
`else
    always_comb begin
        lamp_d = (state_d == ST_PENDING);
    end
`endif

    always_ff @(posedge pin3_clk_16mhz or negedge pin2_rst_n) begin
        if (!pin2_rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            ped_req_q    <= 1'b0;
            lamp_q       <= 1'b0;
            press_seen_q <= 1'b0;
`ifdef PED_WAIT_BLINK_EN
            blink_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ped_req_q    <= (state_d == ST_PENDING);
            lamp_q       <= lamp_d;
            press_seen_q <= press;
`ifdef PED_WAIT_BLINK_EN
            blink_q      <= blink_d;
`endif
        end
    end

    assign ped_req         = ped_req_q;
    assign pin10_wait_lamp = lamp_q;
    assign press_seen      = press_seen_q;

endmodule

// File: tb/tb_ped_request.sv
// Randomised bench for ped_request against a window/event-level reference model.
// Honours PED_WAIT_BLINK_EN when the same macro is defined for the bench.
module tb_ped_request;

    localparam int TS   = 100;
    localparam int DC   = 8;
    localparam int CS   = 2;
    localparam int NCD  = CS * TS;
    localparam int HALF = TS / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn   = 1'b1;
    logic ack   = 1'b0;
    logic ped_req;
    logic lamp;
    logic seen;

    always #5 clk = ~clk;

    ped_request #(
        .TIMER_SCALE    (TS),
        .DEBOUNCE_CYCLES(DC),
        .COOLDOWN_S     (CS)
    ) dut (
        .pin3_clk_16mhz (clk),
        .pin2_rst_n     (rst_n),
        .pin9_button_n  (btn),
        .ped_ack        (ack),
        .ped_req        (ped_req),
        .pin10_wait_lamp(lamp),
        .press_seen     (seen)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: raw sample history, accepted level, request mode, cycle counts.
    logic q[$];
    logic deb_m;
    logic fell_m;
    int   mode_m;
    int   cd_m;
    int   ent_m;
    int   cyc;
    logic exp_req;
    logic exp_lamp;
    logic exp_seen;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i <= DC; i++) q.push_back(1'b1);
        deb_m    = 1'b1;
        fell_m   = 1'b0;
        mode_m   = 0;
        cd_m     = 0;
        ent_m    = 0;
        exp_req  = 1'b0;
        exp_lamp = 1'b0;
        exp_seen = 1'b0;
    endtask

    task automatic model_edge(input logic b, input logic a);
        logic press;
        logic flip;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        press = fell_m;
        flip = 1'b1;
        for (int i = 0; i < DC; i++) begin
            if (q[i] == deb_m) flip = 1'b0;
        end
        fell_m = flip && deb_m;
        if (flip) deb_m = ~deb_m;
        void'(q.pop_front());
        q.push_back(b);
        if (mode_m == 0) begin
            if (press) begin
                mode_m = 1;
                ent_m  = cyc;
            end
        end else if (mode_m == 1) begin
            if (a) begin
                mode_m = (NCD > 0) ? 2 : 0;
                cd_m   = 0;
            end
        end else begin
            cd_m++;
            if (cd_m >= NCD) mode_m = 0;
        end
        exp_req  = (mode_m == 1);
        exp_seen = press;
`ifdef PED_WAIT_BLINK_EN
        exp_lamp = (mode_m == 1) && (((cyc - ent_m) / HALF) % 2 == 0);
`else
        exp_lamp = (mode_m == 1);
`endif
    endtask

    task automatic step(input logic b, input logic a);
        btn = b;
        ack = a;
        @(posedge clk);
        model_edge(b, a);
        #1;
        chk("ped_req", ped_req, exp_req);
        chk("lamp", lamp, exp_lamp);
        chk("press_seen", seen, exp_seen);
    endtask

    int lat;
    int seen_cnt;
    int req_any;
    int len;
    logic rb;

    initial begin
        cyc = 0;
        model_reset();
        #1;
        chk("rst_req", ped_req, 0);
        chk("rst_lamp", lamp, 0);
        chk("rst_seen", seen, 0);
        repeat (5) step(1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (1000) step(1'b1, 1'b0);

        lat = -1;
        seen_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            if (seen === 1'b1) seen_cnt++;
            if (ped_req === 1'b1 && lat < 0) lat = i;
        end
        chk("press_latency", lat, 10);
        chk("press_seen_len", seen_cnt, 1);
        repeat (130) step(1'b1, 1'b0);

        step(1'b1, 1'b1);
        chk("ack_drop", ped_req, 0);
        seen_cnt = 0;
        req_any = 0;
        for (int i = 0; i < 190; i++) begin
            step(((i / 15) % 2 == 0) ? 1'b0 : 1'b1, 1'b0);
            if (seen === 1'b1) seen_cnt++;
            if (ped_req === 1'b1) req_any = 1;
        end
        chk("cool_press_pulses", (seen_cnt > 0) ? 1 : 0, 1);
        chk("cool_no_req", req_any, 0);
        repeat (30) step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        chk("post_cool_req", ped_req, 1);

        repeat (20) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        req_any = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b0);
            if (ped_req === 1'b1) req_any = 1;
        end
        chk("held_no_rereq", req_any, 0);
        repeat (20) step(1'b1, 1'b0);

        seen_cnt = 0;
        req_any = 0;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, DC - 1);
            repeat (len) begin
                step(1'b0, 1'b0);
                if (seen === 1'b1) seen_cnt++;
                if (ped_req === 1'b1) req_any = 1;
            end
            len = $urandom_range(1, 7);
            repeat (len) begin
                step(1'b1, 1'b0);
                if (seen === 1'b1) seen_cnt++;
                if (ped_req === 1'b1) req_any = 1;
            end
        end
        chk("bounce_no_seen", seen_cnt, 0);
        chk("bounce_no_req", req_any, 0);
        repeat (12) step(1'b1, 1'b0);

        repeat (10) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("idle_simul_req", ped_req, 1);
        repeat (20) step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("pend_simul_req", ped_req, 0);
        chk("pend_simul_seen", seen, 1);
        repeat (20) step(1'b1, 1'b0);

        for (int n = 0; n < 3000; ) begin
            rb = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 25);
            for (int j = 0; j < len; j++) begin
                step(rb, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
                n++;
            end
        end

        repeat (260) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        chk("pre_async_req", ped_req, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", ped_req, 0);
        chk("async_rst_lamp", lamp, 0);
        model_reset();
        repeat (3) step(1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (50) step(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
